// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: writeback source encodings and register-file geometry.
package mips_pkg;

  localparam int unsigned REG_NUM = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned DATA_W  = 32;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_DM   = 2'b01;
  localparam logic [1:0] WB_PC8  = 2'b10;
  localparam logic [1:0] WB_NONE = 2'b11;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  // Writeback source mux; also used by the hazard unit's forwarding-source logic.
  function automatic word_t wb_mux(input logic [1:0] wsel, input word_t alu, input word_t dm,
                                   input word_t pc8);
    word_t res;
    res = '0;
    case (wsel)
      WB_ALU:  res = alu;
      WB_DM:   res = dm;
      WB_PC8:  res = pc8;
      default: res = '0;
    endcase
    return res;
  endfunction

  // A write commits only with enable, a non-zero destination and a real source.
  function automatic logic wb_commit(input logic we, input reg_addr_t wa, input logic [1:0] wsel);
    return we && (wa != '0) && (wsel != WB_NONE);
  endfunction

endpackage

// File: rtl/wb_sel.sv
// Combinational writeback-source select producing the W-stage write data.
module wb_sel
  import mips_pkg::*;
(
  input  logic [1:0]        wselW,
  input  logic [DATA_W-1:0] aluoutW,
  input  logic [DATA_W-1:0] dmW,
  input  logic [DATA_W-1:0] pc8W,
  output logic [DATA_W-1:0] wdW
);

  logic [DATA_W-1:0] w_wd;

  always_comb begin
    w_wd = wb_mux(wselW, aluoutW, dmW, pc8W);
  end

  assign wdW = w_wd;

endmodule

// File: rtl/grf_w.sv
// W-stage register file: selects writeback data, commits it, and serves two D-stage reads with
// same-cycle write-through bypass.
module grf_w
  import mips_pkg::*;
#(
  parameter bit TRACE_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc8W,
  input  logic [DATA_W-1:0] dmW,
  input  logic [DATA_W-1:0] aluoutW,
  input  logic [REG_AW-1:0] waW,
  input  logic [1:0]        wselW,
  input  logic              weW,
  input  logic [REG_AW-1:0] ra1D,
  input  logic [REG_AW-1:0] ra2D,
  output logic [DATA_W-1:0] rd1D,
  output logic [DATA_W-1:0] rd2D,
  output logic [DATA_W-1:0] wdW,
  output logic [DATA_W-1:0] wr_cnt
);

  logic [DATA_W-1:0] r_regs [REG_NUM];
  logic [DATA_W-1:0] r_wr_cnt;
  logic [DATA_W-1:0] w_wd;
  logic              w_wr_eff;

  wb_sel u_wb_sel (
    .wselW   (wselW),
    .aluoutW (aluoutW),
    .dmW     (dmW),
    .pc8W    (pc8W),
    .wdW     (w_wd)
  );

  assign w_wr_eff = wb_commit(weW, waW, wselW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        r_regs[i] <= '0;
      end
      r_wr_cnt <= '0;
    end else if (w_wr_eff) begin
      r_regs[waW] <= w_wd;
      r_wr_cnt    <= r_wr_cnt + 32'd1;
    end
  end

  // $0 reads as zero even when a bypass would otherwise match.
  assign rd1D = (ra1D == '0) ? '0 : ((w_wr_eff && (ra1D == waW)) ? w_wd : r_regs[ra1D]);
  assign rd2D = (ra2D == '0) ? '0 : ((w_wr_eff && (ra2D == waW)) ? w_wd : r_regs[ra2D]);

  assign wdW    = w_wd;
  assign wr_cnt = r_wr_cnt;

  if (TRACE_EN) begin : g_trace
    always_ff @(posedge clk) begin
      if (!rst && w_wr_eff) begin
        $display("@%h: $%0d <= %h", pc8W - 32'd8, waW, w_wd);
      end
    end
  end

endmodule

// File: tb/tb_grf_w.sv
// Bench for grf_w: array-based reference model checked every cycle, plus directed literal checks.
module tb_grf_w;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc8W, dmW, aluoutW;
  logic [4:0]  waW, ra1D, ra2D;
  logic [1:0]  wselW;
  logic        weW;
  logic [31:0] rd1D, rd2D, wdW, wr_cnt;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  grf_w #(.TRACE_EN(1'b0)) dut (
    .clk     (clk),
    .rst     (rst),
    .pc8W    (pc8W),
    .dmW     (dmW),
    .aluoutW (aluoutW),
    .waW     (waW),
    .wselW   (wselW),
    .weW     (weW),
    .ra1D    (ra1D),
    .ra2D    (ra2D),
    .rd1D    (rd1D),
    .rd2D    (rd2D),
    .wdW     (wdW),
    .wr_cnt  (wr_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_wd();
    if (wselW == 2'd0) return aluoutW;
    if (wselW == 2'd1) return dmW;
    if (wselW == 2'd2) return pc8W;
    return 32'd0;
  endfunction

  function automatic bit m_wr();
    return (weW == 1'b1) && (waW != 5'd0) && (wselW != 2'd3);
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_wr() && a == waW) return m_wd();
    return m_regs[a];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      m_cnt <= 32'd0;
    end else if (m_wr()) begin
      m_regs[waW] <= m_wd();
      m_cnt       <= m_cnt + 32'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("model_wdW", wdW, m_wd());
    chk("model_rd1D", rd1D, m_rd(ra1D));
    chk("model_rd2D", rd2D, m_rd(ra2D));
    chk("model_wr_cnt", wr_cnt, m_cnt);
  end

  task automatic drive(input logic [4:0] wa, input logic [1:0] ws, input logic we,
                       input logic [31:0] alu, input logic [31:0] dm, input logic [31:0] pc8,
                       input logic [4:0] r1, input logic [4:0] r2);
    waW = wa; wselW = ws; weW = we; aluoutW = alu; dmW = dm; pc8W = pc8; ra1D = r1; ra2D = r2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(5'd0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0);
    #1 rst = 1'b1;
    #2;
    chk("reset_rd1D", rd1D, 32'd0);
    chk("reset_wr_cnt", wr_cnt, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;

    // $5 = 0x1234, then async reset mid-cycle
    step();
    drive(5'd5, WB_ALU, 1'b1, 32'h1234, 32'd0, 32'h1008, 5'd5, 5'd0);
    step();
    drive(5'd0, WB_ALU, 1'b0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0);
    #1;
    chk("write5", rd1D, 32'h1234);
    chk("write5_cnt", wr_cnt, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_rd1D", rd1D, 32'd0);
    chk("async_rst_cnt", wr_cnt, 32'd0);

    // write coinciding with asserted reset is dropped
    drive(5'd6, WB_ALU, 1'b1, 32'h66, 32'd0, 32'd0, 5'd0, 5'd0);
    step();
    drive(5'd0, WB_ALU, 1'b0, 32'd0, 32'd0, 32'd0, 5'd6, 5'd0);
    #1 rst = 1'b0;
    #1;
    chk("rst_drop_rd", rd1D, 32'd0);
    chk("rst_drop_cnt", wr_cnt, 32'd0);

    // source select on $8
    step();
    drive(5'd8, WB_ALU, 1'b1, 32'hA, 32'hB, 32'h3008, 5'd0, 5'd0);
    #1 chk("sel_alu", wdW, 32'hA);
    step();
    drive(5'd8, WB_DM, 1'b1, 32'hA, 32'hB, 32'h3008, 5'd0, 5'd8);
    #1 chk("sel_dm", wdW, 32'hB);
    chk("sel_prev8", rd2D, 32'hB);
    step();
    drive(5'd8, WB_PC8, 1'b1, 32'hA, 32'hB, 32'h3008, 5'd0, 5'd0);
    #1 chk("sel_pc8", wdW, 32'h3008);
    step();
    drive(5'd0, WB_ALU, 1'b0, 32'd0, 32'd0, 32'd0, 5'd8, 5'd0);
    #1;
    chk("sel_final", rd1D, 32'h3008);
    chk("sel_cnt", wr_cnt, 32'd3);

    // bypass on both ports
    drive(5'd9, WB_ALU, 1'b1, 32'hDEAD, 32'd0, 32'd0, 5'd9, 5'd9);
    #1;
    chk("bypass_rd1", rd1D, 32'hDEAD);
    chk("bypass_rd2", rd2D, 32'hDEAD);
    step();
    drive(5'd0, WB_ALU, 1'b0, 32'd0, 32'd0, 32'd0, 5'd9, 5'd8);
    #1;
    chk("bypass_commit", rd1D, 32'hDEAD);
    chk("bypass_cnt", wr_cnt, 32'd4);

    // $0 protection
    drive(5'd0, WB_ALU, 1'b1, 32'hFFFF, 32'd0, 32'd0, 5'd0, 5'd0);
    #1;
    chk("zero_pre", rd1D, 32'd0);
    chk("zero_wd", wdW, 32'hFFFF);
    step();
    chk("zero_post", rd1D, 32'd0);
    chk("zero_cnt", wr_cnt, 32'd4);

    // bubbles leave $3 alone
    drive(5'd3, WB_ALU, 1'b1, 32'h33, 32'd0, 32'd0, 5'd3, 5'd0);
    step();
    drive(5'd3, WB_NONE, 1'b1, 32'h77, 32'h78, 32'h79, 5'd3, 5'd3);
    #1;
    chk("bubble_wd", wdW, 32'd0);
    chk("bubble_rd_pre", rd1D, 32'h33);
    step();
    chk("bubble_rd_post", rd2D, 32'h33);
    drive(5'd3, WB_ALU, 1'b0, 32'h99, 32'd0, 32'd0, 5'd3, 5'd0);
    #1 chk("we0_rd_pre", rd1D, 32'h33);
    step();
    chk("we0_rd_post", rd1D, 32'h33);
    chk("bubble_cnt", wr_cnt, 32'd5);

    // back-to-back writes to $4
    drive(5'd4, WB_ALU, 1'b1, 32'h1, 32'h2, 32'd0, 5'd0, 5'd0);
    step();
    drive(5'd4, WB_DM, 1'b1, 32'h1, 32'h2, 32'd0, 5'd0, 5'd0);
    step();
    drive(5'd0, WB_ALU, 1'b0, 32'd0, 32'd0, 32'd0, 5'd4, 5'd3);
    #1;
    chk("b2b_last_wins", rd1D, 32'h2);
    chk("b2b_cnt", wr_cnt, 32'd7);

    // counter wrap
    force dut.r_wr_cnt = 32'hFFFF_FFFF;
    m_cnt <= 32'hFFFF_FFFF;
    #1 release dut.r_wr_cnt;
    #1 chk("wrap_pre", wr_cnt, 32'hFFFF_FFFF);
    drive(5'd10, WB_ALU, 1'b1, 32'h5, 32'd0, 32'd0, 5'd0, 5'd0);
    step();
    drive(5'd0, WB_ALU, 1'b0, 32'd0, 32'd0, 32'd0, 5'd10, 5'd4);
    #1;
    chk("wrap_cnt", wr_cnt, 32'd0);
    chk("wrap_data", rd1D, 32'h5);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
